fetch_stage_f: RTL and testbench
================================

# fetch_stage_f

Instruction-fetch stage for the RV32I five-stage pipeline. Owns the program counter and a variable-latency instruction-memory request/response port. Presents `Ins_f`, `Pc_f` and `Pc_plus_f` to the F/D pipeline register. Honours the hazard unit's `Stall_f` and the execute stage's branch/jump redirect, and emits a NOP bubble whenever no fetched instruction is valid.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `NOP_INS`, default `32'h0000_0013` (`addi x0,x0,0`): instruction presented when `Valid_f` = 0.

Ports:
- `Clk`  in  1  Rising-edge clock; the only clock.
- `Reset`  in  1  Synchronous, active-high reset.
- `Stall_f`  in  1  From hazard unit; F/D is holding, so the current output must be held.
- `Pc_src_e`  in  1  Taken branch/jump in execute; redirect fetch.
- `Pc_target_e`  in  32  Redirect target; bits [1:0] forced to 0 on capture.
- `Imem_req`  out  1  Request strobe; asserted for exactly the issue cycle.
- `Imem_addr`  out  32  Request address; valid when `Imem_req` = 1.
- `Imem_rdata`  in  32  Returned instruction word.
- `Imem_valid`  in  1  `Imem_rdata` valid. Arrives ≥1 cycle after `Imem_req`. At most one request is outstanding.
- `Ins_f`  out  32  Instruction to F/D.
- `Pc_f`  out  32  Address of `Ins_f`.
- `Pc_plus_f`  out  32  `Pc_f + 4`.
- `Valid_f`  out  1  `Ins_f` holds a real fetched instruction.

## Operation
- Internal state: `Pc_reg` (32 bits), `Ins_buf` (32 bits), and a four-state FSM: FETCH, WAIT, READY, DISCARD.
- Output mapping:
  - `Pc_f` = `Pc_reg`.
  - `Pc_plus_f` = `Pc_reg + 4`, 32-bit modulo, so `0xFFFF_FFFC` → `0x0000_0000`.
  - `Ins_f` = `Ins_buf` in READY, otherwise `NOP_INS`.
  - `Valid_f` = 1 only in READY.
- FETCH:
  - If `Pc_src_e` = 0: `Imem_req` = 1, `Imem_addr` = `Pc_reg`, go to WAIT.
  - If `Pc_src_e` = 1: `Imem_req` = 0, `Pc_reg` ← target, stay in FETCH.
- WAIT (no request issued):
  - `Imem_valid` & !`Pc_src_e`: `Ins_buf` ← `Imem_rdata`, go to READY.
  - `Pc_src_e` & `Imem_valid`: drop the data, `Pc_reg` ← target, go to FETCH.
  - `Pc_src_e` & !`Imem_valid`: `Pc_reg` ← target, go to DISCARD.
- DISCARD:
  - Waits for the stale response. On `Imem_valid`, drop the data and go to FETCH.
  - Any `Pc_src_e` seen here updates `Pc_reg` to the new target; the state does not change for that reason.
- READY. Priority order is Reset > `Pc_src_e` > `Stall_f`:
  - `Pc_src_e`: `Pc_reg` ← target, no request, go to FETCH.
  - else `Stall_f`: hold all state; outputs remain stable.
  - else: `Imem_req` = 1, `Imem_addr` = `Pc_reg + 4`, `Pc_reg` ← `Pc_reg + 4`, go to WAIT.
- `Stall_f` is ignored outside READY. A bubble is a NOP, so holding it is harmless.
- `Imem_valid` is ignored in FETCH and READY. The environment never sends such a response.
- `Imem_rdata` is never sampled outside WAIT.

## Timing
- Reset (synchronous, any state, mid-transaction included):
  - Next edge: `Pc_reg` = `RESET_PC`, state = FETCH, `Valid_f` = 0, `Ins_f` = `NOP_INS`, `Pc_f` = `RESET_PC`, `Pc_plus_f` = `RESET_PC + 4`.
  - `Imem_req` = 0 while `Reset` is high.
  - An outstanding request is abandoned; the memory is reset in the same cycle.
- First request: `Imem_req` rises in the first cycle after `Reset` deasserts, with `Imem_addr` = `RESET_PC`.
- Latency: with a 1-cycle memory, `Valid_f` rises 2 cycles after the FETCH issue.
- Throughput: with a 1-cycle memory and no stalls, one instruction every 2 cycles (READY → WAIT → READY).
- Redirect: `Pc_src_e` sampled at edge N makes `Pc_f` = target from cycle N+1 and `Valid_f` = 0 in cycle N+1. This kills any in-flight or held instruction.
- Simultaneous `Pc_src_e` and `Stall_f` in READY: the redirect wins.
- Simultaneous `Pc_src_e` and `Imem_valid` in WAIT: the data is dropped.
- All outputs are registered-state functions; there are no combinational paths from `Stall_f` or `Imem_valid` to `Ins_f`/`Pc_f`.
- The exception is `Imem_req`/`Imem_addr`, which depend combinationally on `Stall_f` and `Pc_src_e` in READY and on `Pc_src_e` in FETCH.

## Test plan
- **Reset and sequential fetch.** Reset 2 cycles, `RESET_PC` = 0, 1-cycle memory returning `addr | 0x100`. Required: `Imem_addr` sequence 0, 4, 8; `Valid_f` pulses with `Ins_f` 0x100, 0x104, 0x108; NOP between pulses.
- **Stall hold.** `Stall_f` high 3 cycles while READY at `Pc_f` = 8. Required: `Ins_f`/`Pc_f`/`Pc_plus_f` stable at 0x108/8/0xC; `Imem_req` = 0; the next request is 0xC after release.
- **Redirect during WAIT with a 3-cycle memory.** `Pc_src_e` with target 0x40 in the first WAIT cycle. Required: the stale response is dropped, the next `Imem_addr` = 0x40, and `Ins_f` never shows the stale word.
- **Redirect versus stall in READY.** `Pc_src_e` and `Stall_f` both high, target 0x83. Required: next cycle `Pc_f` = 0x80 and `Valid_f` = 0, then a request to 0x80.
- **Wrap-around.** `RESET_PC` = 0xFFFF_FFFC. Required: `Pc_plus_f` = 0, and the second request address = 0x0000_0000.
- **Reset mid-WAIT** (5-cycle memory, reset at WAIT cycle 2). Required: the state matches the post-reset values, and the first request after reset goes to `RESET_PC`.

Source files
------------

// File: rtl/fetch_stage_f.sv
// fetch_stage_f: RV32I fetch stage with PC, variable-latency imem port and redirect/stall handling
module fetch_stage_f #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall_f,
    input  logic        Pc_src_e,
    input  logic [31:0] Pc_target_e,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    input  logic [31:0] Imem_rdata,
    input  logic        Imem_valid,
    output logic [31:0] Ins_f,
    output logic [31:0] Pc_f,
    output logic [31:0] Pc_plus_f,
    output logic        Valid_f
);
    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] READY   = 2'd2;
    localparam logic [1:0] DISCARD = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc_reg, ins_buf, target, pc_next;

    assign target  = Pc_target_e & ~32'h3;
    assign pc_next = pc_reg + 32'd4;

    always_comb begin
        Imem_req  = !Reset && !Pc_src_e && (state == FETCH || (state == READY && !Stall_f));
        Imem_addr = (state == READY) ? pc_next : pc_reg;
        Valid_f   = (state == READY);
        Ins_f     = (state == READY) ? ins_buf : NOP_INS;
        Pc_f      = pc_reg;
        Pc_plus_f = pc_next;
    end

    // a redirect in WAIT without data leaves a stale response in flight; DISCARD absorbs it
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_reg  <= RESET_PC;
            ins_buf <= NOP_INS;
            state   <= FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (Pc_src_e) pc_reg <= target;
                    else state <= WAIT;
                end
                WAIT: begin
                    if (Pc_src_e) begin
                        pc_reg <= target;
                        state  <= Imem_valid ? FETCH : DISCARD;
                    end else if (Imem_valid) begin
                        ins_buf <= Imem_rdata;
                        state   <= READY;
                    end
                end
                READY: begin
                    if (Pc_src_e) begin
                        pc_reg <= target;
                        state  <= FETCH;
                    end else if (!Stall_f) begin
                        pc_reg <= pc_next;
                        state  <= WAIT;
                    end
                end
                default: begin
                    if (Pc_src_e) pc_reg <= target;
                    if (Imem_valid) state <= FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage_f.sv
// tb_fetch_stage_f: scoreboard bench for fetch_stage_f with behavioural variable-latency memory
module tb_fetch_stage_f;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall_f = 1'b0;
    logic        Pc_src_e = 1'b0;
    logic [31:0] Pc_target_e = '0;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic [31:0] Imem_rdata = '0;
    logic        Imem_valid = 1'b0;
    logic [31:0] Ins_f, Pc_f, Pc_plus_f;
    logic        Valid_f;

    logic        w_req, w_valid = 1'b0, w_vf;
    logic [31:0] w_addr, w_rdata = '0, w_ins, w_pc, w_plus;

    int total = 0;
    int bad = 0;
    int mem_lat = 1;
    int cnt = 0;
    logic [31:0] pend = '0;
    logic prev_v = 1'b0;
    logic [31:0] exp_req[$];
    logic [63:0] exp_ins[$];

    fetch_stage_f dut (
        .Clk(Clk), .Reset(Reset), .Stall_f(Stall_f), .Pc_src_e(Pc_src_e),
        .Pc_target_e(Pc_target_e), .Imem_req(Imem_req), .Imem_addr(Imem_addr),
        .Imem_rdata(Imem_rdata), .Imem_valid(Imem_valid), .Ins_f(Ins_f),
        .Pc_f(Pc_f), .Pc_plus_f(Pc_plus_f), .Valid_f(Valid_f)
    );

    fetch_stage_f #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .Clk(Clk), .Reset(Reset), .Stall_f(1'b0), .Pc_src_e(1'b0),
        .Pc_target_e(32'h0), .Imem_req(w_req), .Imem_addr(w_addr),
        .Imem_rdata(w_rdata), .Imem_valid(w_valid), .Ins_f(w_ins),
        .Pc_f(w_pc), .Pc_plus_f(w_plus), .Valid_f(w_vf)
    );

    always #5 Clk = ~Clk;

    // memory returns addr | 0x100 after mem_lat cycles
    always @(posedge Clk) begin
        if (Reset) begin
            cnt        <= 0;
            Imem_valid <= 1'b0;
        end else begin
            Imem_valid <= 1'b0;
            if (Imem_req) begin
                pend <= Imem_addr;
                if (mem_lat == 1) begin
                    Imem_valid <= 1'b1;
                    Imem_rdata <= Imem_addr | 32'h100;
                end else cnt <= mem_lat - 1;
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    Imem_valid <= 1'b1;
                    Imem_rdata <= pend | 32'h100;
                end
            end
        end
    end

    always @(posedge Clk) begin
        w_valid <= !Reset && w_req;
        w_rdata <= w_addr | 32'h100;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_ready(input int bound);
        int n = 0;
        while (!Valid_f && n < bound) begin
            go(1);
            n++;
        end
        if (!Valid_f) begin
            total++;
            bad++;
            $display("FAIL wait_ready actual=timeout expected=Valid_f within %0d cycles", bound);
        end
    endtask

    always @(negedge Clk) begin
        if (Imem_req) begin
            if (exp_req.size() == 0) begin
                total++;
                bad++;
                $display("FAIL req_unexpected actual=%h expected=no request", Imem_addr);
            end else chk("req_addr", Imem_addr, exp_req.pop_front());
        end
        if (Valid_f && !prev_v) begin
            if (exp_ins.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ins_unexpected actual=%h expected=no instruction", Ins_f);
            end else begin
                logic [63:0] e;
                e = exp_ins.pop_front();
                chk("ins_f", Ins_f, e[63:32]);
                chk("ins_pc_f", Pc_f, e[31:0]);
            end
        end
        prev_v = Valid_f;
    end

    initial begin
        exp_req = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_ins = '{{32'h100, 32'h0}, {32'h104, 32'h4}, {32'h108, 32'h8}, {32'h10C, 32'hC}};
        go(2);
        chk("rst_valid", {31'b0, Valid_f}, 32'd0);
        chk("rst_ins", Ins_f, 32'h13);
        chk("rst_pc", Pc_f, 32'h0);
        chk("rst_pc_plus", Pc_plus_f, 32'h4);
        chk("rst_req", {31'b0, Imem_req}, 32'd0);
        Reset = 1'b0;
        #1;
        chk("wrap_pc_plus", w_plus, 32'h0);
        chk("wrap_req1", {31'b0, w_req}, 32'd1);
        chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
        go(2);
        chk("wrap_req2", {31'b0, w_req}, 32'd1);
        chk("wrap_addr2", w_addr, 32'h0);
        chk("wrap_ins", w_ins, 32'hFFFF_FFFC);
        go(4);
        Stall_f = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ins", Ins_f, 32'h108);
            chk("stall_pc", Pc_f, 32'h8);
            chk("stall_pc_plus", Pc_plus_f, 32'hC);
            chk("stall_req", {31'b0, Imem_req}, 32'd0);
            chk("stall_valid", {31'b0, Valid_f}, 32'd1);
            go(1);
        end
        Stall_f = 1'b0;
        exp_req.push_back(32'h10);
        go(1);
        wait_ready(10);
        mem_lat = 3;
        go(1);
        Pc_src_e = 1'b1;
        Pc_target_e = 32'h40;
        go(1);
        Pc_src_e = 1'b0;
        chk("redir_pc", Pc_f, 32'h40);
        chk("redir_valid", {31'b0, Valid_f}, 32'd0);
        exp_req.push_back(32'h40);
        exp_ins.push_back({32'h140, 32'h40});
        go(1);
        wait_ready(20);
        Pc_src_e = 1'b1;
        Stall_f = 1'b1;
        Pc_target_e = 32'h83;
        #1;
        chk("rs_req", {31'b0, Imem_req}, 32'd0);
        go(1);
        Pc_src_e = 1'b0;
        Stall_f = 1'b0;
        chk("rs_pc", Pc_f, 32'h80);
        chk("rs_valid", {31'b0, Valid_f}, 32'd0);
        chk("rs_ins", Ins_f, 32'h13);
        exp_req.push_back(32'h80);
        exp_ins.push_back({32'h180, 32'h80});
        wait_ready(20);
        exp_req.push_back(32'h84);
        mem_lat = 5;
        go(2);
        Reset = 1'b1;
        #1;
        chk("rstw_req_hi", {31'b0, Imem_req}, 32'd0);
        go(1);
        chk("rstw_pc", Pc_f, 32'h0);
        chk("rstw_pc_plus", Pc_plus_f, 32'h4);
        chk("rstw_valid", {31'b0, Valid_f}, 32'd0);
        chk("rstw_ins", Ins_f, 32'h13);
        chk("rstw_req", {31'b0, Imem_req}, 32'd0);
        Reset = 1'b0;
        exp_req.push_back(32'h0);
        exp_ins.push_back({32'h100, 32'h0});
        go(1);
        wait_ready(30);
        Stall_f = 1'b1;
        go(3);
        chk("req_queue_left", exp_req.size(), 32'd0);
        chk("ins_queue_left", exp_ins.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
